// File: rtl/freq_meas_sched.sv
// Schedules one shared frequency counter across CH_NUM muxed clocks: round-robin scan plus
// on-demand requests. Define FREQ_SCHED_STABLE_CHECK_EN to enable the two-sample stability check.
module freq_meas_sched #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned SETTLE_CYC  = 1000,
    parameter int unsigned TIMEOUT_CYC = 250000000,
    parameter int unsigned TOL_HZ      = 1000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rstn_i,
    input  logic              scan_en_i,
    input  logic              req_vld_i,
    input  logic [CH_W-1:0]   req_ch_i,
    output logic              req_ack_o,
    output logic [CH_W-1:0]   ch_sel_o,
    output logic              meas_restart_o,
    input  logic [31:0]       meas_hz_i,
    input  logic              meas_vld_i,
    input  logic [CH_W-1:0]   rd_addr_i,
    output logic [31:0]       rd_hz_o,
    output logic [CH_NUM-1:0] ch_vld_o,
    output logic [CH_NUM-1:0] ch_dead_o,
    output logic [CH_NUM-1:0] ch_unstb_o,
    output logic              scan_done_o
);

    localparam logic [CH_W:0]   LP_CH_NUM    = (CH_W + 1)'(CH_NUM);
    localparam logic [CH_W-1:0] LP_CH_LAST   = CH_W'(CH_NUM - 1);
    localparam logic [31:0]     LP_SETTLE_LD = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]     LP_WD_LD     = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StDiscard,
        StSample,
        StStore,
        StNext
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_cur_ch;
    logic [CH_W-1:0]   r_ch_sel;
    logic              r_cur_req;
    logic              r_live;
    logic              r_timeout;
    logic [31:0]       r_settle;
    logic [31:0]       r_wdog;
    logic [31:0]       r_result;
    logic [31:0]       r_rd_hz;
    logic [31:0]       r_table [CH_NUM];
    logic [CH_NUM-1:0] r_vld;
    logic [CH_NUM-1:0] r_dead;

    logic              w_in_capture;
    logic              w_req_take;
    logic              w_ptr_wrap;
    logic [CH_W-1:0]   w_ptr_adv;
    logic [CH_W-1:0]   w_ptr_nxt;
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_wd_exp;
    logic              w_sample_done;
    logic              w_to_select;

    // r_live keeps the combinational ack low while reset is held.
    assign w_in_capture = r_live && ((r_state == StIdle) || (r_state == StNext));
    assign w_req_take   = w_in_capture && req_vld_i && ({1'b0, req_ch_i} < LP_CH_NUM);
    assign w_ptr_wrap   = (r_ptr == LP_CH_LAST);
    assign w_ptr_adv    = w_ptr_wrap ? '0 : r_ptr + 1'b1;
    assign w_ptr_nxt    = ((r_state == StNext) && !r_cur_req) ? w_ptr_adv : r_ptr;
    assign w_sel_ch     = w_req_take ? req_ch_i : w_ptr_nxt;
    assign w_wd_exp     = (r_wdog == 32'd0) && !meas_vld_i;
    assign w_to_select  = (w_state_nxt == StSelect) && w_in_capture;

`ifdef FREQ_SCHED_STABLE_CHECK_EN
    logic [31:0]       r_samp_a;
    logic              r_have_a;
    logic [1:0]        r_retry;
    logic              r_unstb_res;
    logic [CH_NUM-1:0] r_unstb;
    logic [31:0]       w_diff;
    logic              w_stable;

    assign w_diff        = (meas_hz_i >= r_samp_a) ? meas_hz_i - r_samp_a : r_samp_a - meas_hz_i;
    assign w_stable      = (w_diff <= TOL_HZ);
    assign w_sample_done = meas_vld_i && r_have_a && (w_stable || (r_retry == 2'd2));
    assign ch_unstb_o    = r_unstb;

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_samp_a    <= '0;
            r_have_a    <= 1'b0;
            r_retry     <= '0;
            r_unstb_res <= 1'b0;
            r_unstb     <= '0;
        end else begin
            if (r_state == StSelect) begin
                r_have_a    <= 1'b0;
                r_retry     <= '0;
                r_unstb_res <= 1'b0;
            end else if ((r_state == StSample) && meas_vld_i) begin
                // B always becomes the next A; the third failed compare ends the channel.
                r_samp_a <= meas_hz_i;
                r_have_a <= 1'b1;
                if (r_have_a && !w_stable) begin
                    r_retry     <= r_retry + 2'd1;
                    r_unstb_res <= (r_retry == 2'd2);
                end
            end
            if ((r_state == StStore) && !r_timeout) begin
                r_unstb[r_cur_ch] <= r_unstb_res;
            end
        end
    end
`else
    assign w_sample_done = meas_vld_i;
    assign ch_unstb_o    = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:    if (w_req_take || scan_en_i) w_state_nxt = StSelect;
            StSelect:  w_state_nxt = StSettle;
            StSettle:  if (r_settle == 32'd0) w_state_nxt = StDiscard;
            StDiscard: begin
                if (meas_vld_i) w_state_nxt = StSample;
                else if (w_wd_exp) w_state_nxt = StStore;
            end
            StSample:  if (w_sample_done || w_wd_exp) w_state_nxt = StStore;
            StStore:   w_state_nxt = StNext;
            StNext:    w_state_nxt = (w_req_take || scan_en_i) ? StSelect : StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_state   <= StIdle;
            r_live    <= 1'b0;
            r_ptr     <= '0;
            r_cur_ch  <= '0;
            r_ch_sel  <= '0;
            r_cur_req <= 1'b0;
            r_timeout <= 1'b0;
            r_settle  <= '0;
            r_wdog    <= '0;
            r_result  <= '0;
            r_rd_hz   <= '0;
            r_vld     <= '0;
            r_dead    <= '0;
            for (int unsigned i = 0; i < CH_NUM; i++) r_table[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_to_select) begin
                r_cur_ch  <= w_sel_ch;
                r_ch_sel  <= w_sel_ch;
                r_cur_req <= w_req_take;
            end
            if (r_state == StNext) r_ptr <= w_ptr_nxt;

            if (r_state == StSelect) r_settle <= LP_SETTLE_LD;
            else if ((r_state == StSettle) && (r_settle != 32'd0)) r_settle <= r_settle - 32'd1;

            // Held loaded through SETTLE so DISCARD starts with a full budget.
            if ((r_state == StSettle) || meas_vld_i) r_wdog <= LP_WD_LD;
            else if (r_wdog != 32'd0) r_wdog <= r_wdog - 32'd1;

            if (r_state == StSelect) begin
                r_timeout <= 1'b0;
            end else if (((r_state == StDiscard) || (r_state == StSample)) && w_wd_exp) begin
                r_timeout <= 1'b1;
                r_result  <= '0;
            end else if ((r_state == StSample) && w_sample_done) begin
                r_result <= meas_hz_i;
            end

            if (r_state == StStore) begin
                r_table[r_cur_ch] <= r_result;
                r_vld[r_cur_ch]   <= !r_timeout;
                r_dead[r_cur_ch]  <= r_timeout;
            end

            r_rd_hz <= ({1'b0, rd_addr_i} < LP_CH_NUM) ? r_table[rd_addr_i] : '0;
        end
    end

    assign req_ack_o      = w_in_capture && req_vld_i;
    assign ch_sel_o       = r_ch_sel;
    assign meas_restart_o = (r_state == StSelect);
    assign scan_done_o    = (r_state == StNext) && !r_cur_req && w_ptr_wrap;
    assign rd_hz_o        = r_rd_hz;
    assign ch_vld_o       = r_vld;
    assign ch_dead_o      = r_dead;

endmodule
